// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: free-running h/v counters with registered
// coordinate, active-area, sync and strobe decode, frozen while i_enable is low.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int COORD_W    = 12
) (
   input  logic               i_pix_clk,
   input  logic               i_reset_n,
   input  logic               i_enable,
   output logic [COORD_W-1:0] o_horz_coord,
   output logic [COORD_W-1:0] o_vert_coord,
   output logic               o_in_active_area,
   output logic               o_horz_sync,
   output logic               o_vert_sync,
   output logic               o_line_start,
   output logic               o_frame_start,
   output logic               o_vblank_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   generate
      if ((longint'(H_TOTAL) - 1 >= (longint'(1) << COORD_W)) ||
          (longint'(V_TOTAL) - 1 >= (longint'(1) << COORD_W))) begin : g_width_check
         $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
   localparam logic               HS_ON  = (H_SYNC_POL != 0);
   localparam logic               VS_ON  = (V_SYNC_POL != 0);

   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic [31:0]        h_ext;
   logic [31:0]        v_ext;
   logic               h_active;
   logic               v_active;
   logic               h_sync_on;
   logic               v_sync_on;
   logic               line_first;

   // Range decode is done at 32 bits so sync-end bounds equal to 2**COORD_W cannot wrap.
   assign h_ext      = 32'(h_cnt);
   assign v_ext      = 32'(v_cnt);
   assign h_active   = h_ext < 32'(H_ACTIVE);
   assign v_active   = v_ext < 32'(V_ACTIVE);
   assign h_sync_on  = (h_ext >= 32'(H_ACTIVE + H_FRONT)) &&
                       (h_ext <  32'(H_ACTIVE + H_FRONT + H_SYNC));
   assign v_sync_on  = (v_ext >= 32'(V_ACTIVE + V_FRONT)) &&
                       (v_ext <  32'(V_ACTIVE + V_FRONT + V_SYNC));
   assign line_first = (h_cnt == '0);

   always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         h_cnt            <= '0;
         v_cnt            <= '0;
         o_horz_coord     <= '0;
         o_vert_coord     <= '0;
         o_in_active_area <= 1'b0;
         o_horz_sync      <= ~HS_ON;
         o_vert_sync      <= ~VS_ON;
         o_line_start     <= 1'b0;
         o_frame_start    <= 1'b0;
         o_vblank_start   <= 1'b0;
      end else if (i_enable) begin
         o_horz_coord     <= h_active ? h_cnt : '0;
         o_vert_coord     <= v_active ? v_cnt : '0;
         o_in_active_area <= h_active && v_active;
         o_horz_sync      <= h_sync_on ? HS_ON : ~HS_ON;
         o_vert_sync      <= v_sync_on ? VS_ON : ~VS_ON;
         o_line_start     <= line_first;
         o_frame_start    <= line_first && (v_cnt == '0);
         o_vblank_start   <= line_first && (v_ext == 32'(V_ACTIVE));
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end else begin
         // Strobes must mark exactly one enabled cycle, so a stalled edge clears them.
         o_line_start   <= 1'b0;
         o_frame_start  <= 1'b0;
         o_vblank_start <= 1'b0;
      end
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the successor to the fixed 800x600 controller. Every horizontal and vertical timing value, the sync polarity and the coordinate width are elaboration-time parameters. All outputs are registered with a fixed 1-cycle latency. It adds a pixel-enable for clock-divided operation and frame, line and vblank strobes, which framebuffer readers and buffer-swap logic downstream of the pixel clock domain consume.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync pulse width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of o_horz_sync (0 = active-low)
V_SYNC_POL, 0, asserted level of o_vert_sync
COORD_W, 12, width of counters and coordinate outputs; H_TOTAL-1 and V_TOTAL-1 must fit in it, checked at elaboration

Ports:
i_pix_clk  in  1  pixel clock; the only clock
i_reset_n  in  1  reset, asynchronous, active-low
i_enable  in  1  advance-enable; when 0 the generator freezes
o_horz_coord  out  COORD_W  x within active line, else 0
o_vert_coord  out  COORD_W  y within active frame, else 0
o_in_active_area  out  1  pixel visible
o_horz_sync  out  1  hsync at the configured polarity
o_vert_sync  out  1  vsync at the configured polarity
o_line_start  out  1  1-cycle strobe, first cycle of each line (x=0)
o_frame_start  out  1  1-cycle strobe, pixel (0,0)
o_vblank_start  out  1  1-cycle strobe, first cycle of line V_ACTIVE

Behaviour:
- One clock, i_pix_clk; reset i_reset_n is asynchronous and active-low.
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Internal counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1.
- Reset: h_cnt=v_cnt=0; coords 0; active 0; strobes 0; syncs at deasserted level (~H_SYNC_POL, ~V_SYNC_POL). Takes effect immediately, with no clock edge, including mid-frame.
- On each rising edge with i_enable=1, outputs are registered from the current counter values, then the counters advance. Outputs therefore lag the counters by exactly 1 cycle.
- Counter advance:
  - h_cnt==H_TOTAL-1 wraps to 0, and v_cnt increments, wrapping V_TOTAL-1 to 0 in the same edge.
  - Otherwise h_cnt increments.
  - No out-of-range state is reachable.
- Decode, all from pre-advance counters:
  - hactive = h_cnt<H_ACTIVE; vactive = v_cnt<V_ACTIVE.
  - o_horz_coord = hactive ? h_cnt : 0.
  - o_vert_coord = vactive ? v_cnt : 0.
  - o_in_active_area = hactive & vactive.
  - hsync asserted when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync asserted when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC, for whole lines.
  - o_line_start = (h_cnt==0).
  - o_frame_start = (h_cnt==0 && v_cnt==0).
  - o_vblank_start = (h_cnt==0 && v_cnt==V_ACTIVE).
- i_enable=0 on an edge: counters, coords, active and syncs hold. All three strobes are forced to 0, so each strobe is asserted for exactly one enabled cycle per event.
- Simultaneous events: at (0,0), o_line_start and o_frame_start are both 1.
- Reset released mid-line: the first enabled edge presents (0,0) with o_frame_start=1.

Test Plan:
Use bench parameters H=8/2/3/2 (H_TOTAL=15), V=4/1/2/1 (V_TOTAL=8), COORD_W=4, polarities 0. Edge k means the k-th enabled edge after reset release.
1. Reset release, i_enable=1 held -> edge 1: x=0,y=0, active=1, o_frame_start=1, o_line_start=1. Edge 8: x=7, active=1. Edge 9: x=0, active=0. Edge 16: x=0,y=1, line_start=1, frame_start=0.
2. Horizontal sync over line 0 -> o_horz_sync=0 at edges 11-13, 1 elsewhere. o_line_start at edges 1,16,31,...
3. Full frame -> o_vblank_start only at edge 61 (v_cnt=4). o_vert_sync=0 for edges 76-105 (lines 5-6, 30 cycles). o_frame_start at edges 1 and 121. y returns to 0 at edge 121. No strobes elsewhere.
4. i_enable toggled 1,0,0,1 across the (0,0) point -> outputs frozen during the low cycles. o_frame_start high only once, strobes 0 while disabled. Total period in enabled edges is unchanged (120).
5. i_reset_n pulsed low asynchronously mid-frame (at y=5, vsync asserted), between clock edges -> syncs go to 1 and coords/active/strobes go to 0 before the next edge. After release, the sequence restarts as in scenario 1.
6. Rebuild with H_SYNC_POL=1, V_SYNC_POL=1 -> reset value of both syncs is 0. o_horz_sync=1 at edges 11-13. All other outputs identical to scenario 1.
